decryption_key_gen: RTL and testbench
=====================================

Name: decryption_key_gen

Overview:
- Companion to the encryption-key validity stage. Takes the public exponent E and totient T and computes the private exponent D = E^-1 mod T using a sequential extended Euclidean algorithm.
- Each quotient comes from a bit-serial restoring divider, so no wide combinational divide is needed.
- Flags whether a valid decryption key exists (gcd(E,T)=1). D then feeds the decryption datapath.

Parameters:
- WIDTH, 256, bit width of E, T and D.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- E  input  WIDTH  public exponent; latched on accepted start
- T  input  WIDTH  totient (P-1)*(Q-1); latched on accepted start
- busy  output  1  high from the cycle after accept until done
- done  output  1  single-cycle completion pulse
- D  output  WIDTH  private exponent, in range 1..T-1 when valid, else 0
- Decryption_key_valid  output  1  high when gcd(E,T)=1 and the precheck passed

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, D=0, Decryption_key_valid=0; all internal registers cleared. Reset mid-operation aborts with no done pulse.
- States: IDLE, CHECK, DIV, UPDATE, FINAL, DONE.
- IDLE:
  - start=1 latches E and T, clears D and Decryption_key_valid, and goes to CHECK.
  - start while not in IDLE is ignored (no queueing).
- CHECK (1 cycle):
  - If E==0, E>=T, or T<2: go to DONE with D=0, valid=0.
  - Otherwise initialise r0=T, r1=E, t0=0, t1=1 and go to DIV.
- DIV (exactly WIDTH cycles): restoring division of r0 by r1, one quotient bit per cycle, MSB first. Produces q=r0/r1 and rem=r0 mod r1.
- UPDATE (1 cycle):
  - (r0,r1) <= (r1, rem)
  - (t0,t1) <= (t1, t0 - q*t1)
  - If the new r1==0, go to FINAL; else go to DIV.
- Coefficient arithmetic:
  - t0 and t1 are WIDTH+1-bit two's complement.
  - q*t1 is truncated to WIDTH+1 bits. This is exact because |t_i| <= T for all Euclid steps.
- FINAL (1 cycle):
  - If r0==1: D <= (t0<0) ? t0+T : t0, truncated to WIDTH, and valid <= 1.
  - Else: D <= 0 and valid <= 0.
- DONE (1 cycle): done=1 for exactly one cycle, then return to IDLE.
- busy is high in CHECK through DONE inclusive and low in IDLE.
- D and Decryption_key_valid hold their values after done until the next accepted start.
- Latency, counting from the accepting clock edge:
  - Normal path: done high in cycle 3 + k*(WIDTH+1), where k is the number of Euclid divisions.
  - Precheck failure: done high in cycle 2.
- Gap between runs: a start in the cycle immediately after done is accepted, so back-to-back operation has a 1-cycle IDLE gap.
- Division by zero cannot occur: r1!=0 is guaranteed on entry to DIV.

Test Plan:
- WIDTH=16. Pulse start with E=17, T=3120 -> k=4; done at cycle 3+4*17=71 after accept; D=2753; valid=1; busy high from cycle 1 through 71.
- E=6, T=3120 (gcd 6) -> done after full Euclid run; D=0; valid=0.
- Boundary inputs:
  - E=1, T=20 -> k=1; D=1; valid=1.
  - E=3, T=20 -> D=7; valid=1.
  - E=20, T=20 -> precheck fail; done at cycle 2; D=0; valid=0.
  - E=0, T=20 -> same precheck-fail response.
- Mid-run events:
  - Assert start repeatedly while busy with different E/T -> ignored; result still matches the first request.
  - Drop reset at cycle 30 of a run -> outputs go to 0 immediately, no done pulse.
  - A new start after reset release completes correctly.
- WIDTH=256. E=65537, T=(P-1)*(Q-1) for two known 128-bit primes -> D matches the reference-model inverse; (E*D) mod T == 1; valid=1.

Source files
------------

// File: rtl/decryption_key_gen.sv
// -----------------------------------------------------------------------------
// decryption_key_gen
//
// Computes the private exponent D = E^-1 mod T with a sequential extended
// Euclidean algorithm. Each Euclid quotient comes from a bit-serial restoring
// divider (one quotient bit per clock), so no wide combinational divider is
// built. The result is flagged valid only when gcd(E,T) == 1 and the operands
// pass a sanity precheck (0 < E < T, T >= 2).
//
// Ports
//   clk                  : rising-edge clock
//   reset                : asynchronous, active-low reset
//   start                : request, sampled only while idle
//   E [WIDTH-1:0]        : public exponent, latched on an accepted start
//   T [WIDTH-1:0]        : totient, latched on an accepted start
//   busy                 : high from the cycle after accept until done
//   done                 : single-cycle completion pulse
//   D [WIDTH-1:0]        : private exponent (1..T-1 when valid, else 0)
//   Decryption_key_valid : high when gcd(E,T) == 1 and the precheck passed
// -----------------------------------------------------------------------------
module decryption_key_gen #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] T,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Decryption_key_valid
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV,
        UPDATE,
        FINAL,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]        e_reg;
    logic [WIDTH-1:0]        t_reg;
    logic [WIDTH-1:0]        r0;
    logic [WIDTH-1:0]        r1;
    // Dividend shift register; quotient bits shift in at the LSB as the
    // dividend bits shift out at the MSB, so after WIDTH steps it holds q.
    logic [WIDTH-1:0]        dvd;
    logic [WIDTH-1:0]        rem;
    logic signed [WIDTH:0]   t0;
    logic signed [WIDTH:0]   t1;
    logic [CNT_W-1:0]        cnt;

    logic [WIDTH:0]          partial;
    logic [WIDTH:0]          diff;
    logic                    qbit;
    logic                    precheck_fail;

    // Coefficient update t0 - q*t1, kept to WIDTH+1 bits. Truncation is exact
    // because every Bezout coefficient is bounded in magnitude by T.
    function automatic logic signed [WIDTH:0] coef_next(
        input logic signed [WIDTH:0] a,
        input logic signed [WIDTH:0] b,
        input logic [WIDTH-1:0]      q
    );
        logic signed [WIDTH:0] qs;
        qs = $signed({1'b0, q});
        return a - qs * b;
    endfunction

    // Map a signed coefficient into the residue range 0..m-1.
    function automatic logic [WIDTH-1:0] to_residue(
        input logic signed [WIDTH:0] c,
        input logic [WIDTH-1:0]      m
    );
        logic signed [WIDTH:0] s;
        s = c[WIDTH] ? (c + $signed({1'b0, m})) : c;
        return s[WIDTH-1:0];
    endfunction

    // One restoring-division step. The partial remainder is always below r1,
    // so after the shift it fits in WIDTH+1 bits; the MSB of the trial
    // subtraction is set exactly when partial < r1.
    assign partial = {rem, dvd[WIDTH-1]};
    assign diff    = partial - {1'b0, r1};
    assign qbit    = ~diff[WIDTH];

    assign precheck_fail = (e_reg == '0) || (e_reg >= t_reg) ||
                           (t_reg < WIDTH'(2));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = CHECK;
            CHECK:   state_next = precheck_fail ? DONE : DIV;
            DIV:     if (cnt == CNT_W'(WIDTH - 1)) state_next = UPDATE;
            UPDATE:  state_next = (rem == '0) ? FINAL : DIV;
            FINAL:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_reg                <= '0;
            t_reg                <= '0;
            r0                   <= '0;
            r1                   <= '0;
            dvd                  <= '0;
            rem                  <= '0;
            t0                   <= '0;
            t1                   <= '0;
            cnt                  <= '0;
            D                    <= '0;
            Decryption_key_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        e_reg                <= E;
                        t_reg                <= T;
                        D                    <= '0;
                        Decryption_key_valid <= 1'b0;
                    end
                end
                CHECK: begin
                    r0  <= t_reg;
                    r1  <= e_reg;
                    t0  <= '0;
                    t1  <= (WIDTH + 1)'(1);
                    dvd <= t_reg;
                    rem <= '0;
                    cnt <= '0;
                end
                DIV: begin
                    rem <= qbit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
                    dvd <= {dvd[WIDTH-2:0], qbit};
                    cnt <= cnt + 1'b1;
                end
                UPDATE: begin
                    // dvd holds q and rem holds r0 mod r1 here.
                    r0  <= r1;
                    r1  <= rem;
                    t0  <= t1;
                    t1  <= coef_next(t0, t1, dvd);
                    // Next division is (old r1) / (rem).
                    dvd <= r1;
                    rem <= '0;
                    cnt <= '0;
                end
                FINAL: begin
                    if (r0 == WIDTH'(1)) begin
                        D                    <= to_residue(t0, t_reg);
                        Decryption_key_valid <= 1'b1;
                    end else begin
                        D                    <= '0;
                        Decryption_key_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decryption_key_gen.sv
module tb_decryption_key_gen;

    localparam int W  = 16;
    localparam int WB = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start;
    logic [W-1:0]  e;
    logic [W-1:0]  t;
    logic          busy;
    logic          done;
    logic [W-1:0]  d;
    logic          valid;

    logic          start_b;
    logic [WB-1:0] e_b;
    logic [WB-1:0] t_b;
    logic          busy_b;
    logic          done_b;
    logic [WB-1:0] d_b;
    logic          valid_b;

    int checks   = 0;
    int failures = 0;

    decryption_key_gen #(.WIDTH(W)) dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .E                    (e),
        .T                    (t),
        .busy                 (busy),
        .done                 (done),
        .D                    (d),
        .Decryption_key_valid (valid)
    );

    decryption_key_gen #(.WIDTH(WB)) dut_wide (
        .clk                  (clk),
        .reset                (reset),
        .start                (start_b),
        .E                    (e_b),
        .T                    (t_b),
        .busy                 (busy_b),
        .done                 (done_b),
        .D                    (d_b),
        .Decryption_key_valid (valid_b)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge while the DUT is idle; returns #1 after
    // the accepting edge, i.e. in cycle 1 of the run.
    task automatic do_start(input logic [W-1:0] e_in, input logic [W-1:0] t_in);
        start = 1'b1;
        e     = e_in;
        t     = t_in;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [W-1:0] e_in, input logic [W-1:0] t_in,
                       input int exp_cyc, input logic [W-1:0] exp_d, input logic exp_v,
                       input bit noise);
        int cyc;
        int busy_low;
        do_start(e_in, t_in);
        cyc      = 1;
        busy_low = 0;
        while (done !== 1'b1 && cyc < exp_cyc + 20) begin
            if (busy !== 1'b1) busy_low++;
            if (noise && cyc < exp_cyc - 3) begin
                start = cyc[0];
                e     = W'($urandom);
                t     = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (busy !== 1'b1) busy_low++;
        check({tag, "_done_cycle"}, cyc, exp_cyc);
        check({tag, "_busy_low_cycles"}, busy_low, 0);
        check({tag, "_D"}, d, exp_d);
        check({tag, "_valid"}, valid, exp_v);
        // Cycle after done: idle, single pulse, outputs held.
        @(posedge clk); #1;
        check({tag, "_done_pulse_end"}, done, 1'b0);
        check({tag, "_busy_idle"}, busy, 1'b0);
        check({tag, "_D_held"}, d, exp_d);
        check({tag, "_valid_held"}, valid, exp_v);
    endtask

    initial begin
        int            done_seen;
        int            cyc;
        logic [WB-1:0] p;
        logic [WB-1:0] q;
        logic [511:0]  prod;

        reset   = 1'b0;
        start   = 1'b0;
        e       = '0;
        t       = '0;
        start_b = 1'b0;
        e_b     = '0;
        t_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_D", d, 0);
        check("rst_valid", valid, 1'b0);
        check("rst_wide_busy", busy_b, 1'b0);
        check("rst_wide_D", d_b, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // k=4: done at 3 + 4*17
        run("e17_t3120", 16'd17, 16'd3120, 71, 16'd2753, 1'b1, 1'b0);
        // 3120/6 exact, k=1, gcd 6
        run("e6_t3120", 16'd6, 16'd3120, 20, 16'd0, 1'b0, 1'b0);
        run("e1_t20", 16'd1, 16'd20, 20, 16'd1, 1'b1, 1'b0);
        // k=3: 20/3, 3/2, 2/1
        run("e3_t20", 16'd3, 16'd20, 54, 16'd7, 1'b1, 1'b0);
        run("e20_t20", 16'd20, 16'd20, 2, 16'd0, 1'b0, 1'b0);
        run("e0_t20", 16'd0, 16'd20, 2, 16'd0, 1'b0, 1'b0);
        run("e17_t3120_noise", 16'd17, 16'd3120, 71, 16'd2753, 1'b1, 1'b1);

        // Reset at cycle 30 of a run
        do_start(16'd17, 16'd3120);
        for (int i = 1; i < 30; i++) begin
            @(posedge clk); #1;
        end
        check("midrun_busy_before_reset", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("midrun_rst_busy", busy, 1'b0);
        check("midrun_rst_done", done, 1'b0);
        check("midrun_rst_D", d, 0);
        check("midrun_rst_valid", valid, 1'b0);
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen++;
        end
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("midrun_no_done_after_reset", done_seen, 0);
        run("after_reset_e3_t20", 16'd3, 16'd20, 54, 16'd7, 1'b1, 1'b0);

        // Wide run: P = 2^128-159, Q = 2^127-1, E = 65537
        p       = (256'd1 << 128) - 256'd159;
        q       = (256'd1 << 127) - 256'd1;
        t_b     = (p - 256'd1) * (q - 256'd1);
        e_b     = 256'd65537;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        cyc     = 1;
        while (done_b !== 1'b1 && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("wide_done_seen", done_b, 1'b1);
        check("wide_valid", valid_b, 1'b1);
        check("wide_D_in_range", (d_b != '0) && (d_b < t_b), 1'b1);
        prod = {256'd0, e_b} * {256'd0, d_b};
        check("wide_ED_mod_T", prod % {256'd0, t_b}, 512'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
